lod_normalizer_pipe: RTL and testbench

//  Pipelined, parametrised sign-magnitude mantissa adder with leading-one detection and normalisation.

---
 rtl/lod_normalizer_pipe.sv | 184 ++++++++++++++++++
 tb/tb_lod_normalizer_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lod_normalizer_pipe.sv
// Three-stage sign-magnitude mantissa adder with leading-one detection and normalisation.
// Elastic valid/ready pipe; a sideband tag travels with each beat.
module lod_normalizer_pipe #(
  parameter int MAN_W = 28,
  parameter int EXP_W = 8,
  parameter int TAG_W = 4,
  localparam int LOC_W = $clog2(MAN_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAN_W-1:0]   a,
  input  logic [MAN_W-1:0]   b,
  input  logic [EXP_W-1:0]   exponent,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MAN_W:0]     out_mant,
  output logic [EXP_W-1:0]   out_exp,
  output logic [LOC_W-1:0]   msb_loc,
  output logic               out_zero,
  output logic               out_ovf,
  output logic [TAG_W-1:0]   out_tag
);

  // Width wide enough to compare a shift count against an exponent without truncation.
  localparam int CMP_W = ((EXP_W > LOC_W) ? EXP_W : LOC_W) + 1;
  localparam logic [LOC_W-1:0] TOP_LOC = LOC_W'(MAN_W - 1);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  // ---------------- Stage valids and elastic handshake ----------------
  logic v1, v2, v3;
  logic rdy1, rdy2, rdy3;

  // A stage can take new data when it is empty or its content moves on this edge.
  assign rdy3     = !v3 || out_ready;
  assign rdy2     = !v2 || rdy3;
  assign rdy1     = !v1 || rdy2;
  assign in_ready = rdy1;

  logic load1, load2, load3;
  assign load1 = in_valid && rdy1;
  assign load2 = v1 && rdy2;
  assign load3 = v2 && rdy3;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (rdy1) v1 <= in_valid;
      if (rdy2) v2 <= v1;
      if (rdy3) v3 <= v2;
    end
  end

  // ---------------- Stage 1: sign-magnitude add ----------------
  function automatic logic [MAN_W:0] to_twos(input logic [MAN_W-1:0] v);
    logic [MAN_W:0] mag;
    mag = {2'b00, v[MAN_W-2:0]};
    // A negative zero negates to zero, so -0 behaves as +0 for free.
    return v[MAN_W-1] ? (~mag + 1'b1) : mag;
  endfunction

  logic [MAN_W:0]   sum_c;
  logic [MAN_W:0]   abs_c;
  logic             s1_sign;
  logic [MAN_W-1:0] s1_mag;
  logic [EXP_W-1:0] s1_exp;
  logic [TAG_W-1:0] s1_tag;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later lines see the updated value;
    // clocked blocks use '<=' so every register samples pre-edge values.
    sum_c = to_twos(a) + to_twos(b);
    abs_c = sum_c[MAN_W] ? (~sum_c + 1'b1) : sum_c;
  end

  // NOTE: pipeline data registers carry no reset; the stage valids already mark them
  // as don't-care, and only the visible output stage is cleared.
  always_ff @(posedge clk) begin
    if (load1) begin
      s1_sign <= sum_c[MAN_W];
      s1_mag  <= abs_c[MAN_W-1:0];
      s1_exp  <= exponent;
      s1_tag  <= in_tag;
    end
  end

  // ---------------- Stage 2: leading-one and zero detect ----------------
  logic [LOC_W-1:0] lod_c;
  logic             zero_c;

  always_comb begin
    // NOTE: default first, so no path through this block leaves lod_c unassigned (no latch).
    lod_c  = '0;
    zero_c = (s1_mag == '0);
    // Ascending scan: the highest set bit is written last and wins.
    for (int i = 0; i < MAN_W; i++) begin
      if (s1_mag[i]) lod_c = LOC_W'(i);
    end
  end

  logic             s2_sign;
  logic [MAN_W-1:0] s2_mag;
  logic [EXP_W-1:0] s2_exp;
  logic [TAG_W-1:0] s2_tag;
  logic [LOC_W-1:0] s2_loc;
  logic             s2_zero;

  always_ff @(posedge clk) begin
    if (load2) begin
      s2_sign <= s1_sign;
      s2_mag  <= s1_mag;
      s2_exp  <= s1_exp;
      s2_tag  <= s1_tag;
      s2_loc  <= lod_c;
      s2_zero <= zero_c;
    end
  end

  // ---------------- Stage 3: normalise and adjust exponent ----------------
  logic [LOC_W-1:0] shift_c;
  logic [CMP_W-1:0] shift_w, exp_w;
  logic [MAN_W:0]   mant_c;
  logic [EXP_W-1:0] exp_c;
  logic [LOC_W-1:0] loc_c;
  logic             zflag_c;
  logic             ovf_c;

  always_comb begin
    shift_c = TOP_LOC - s2_loc;
    shift_w = CMP_W'(shift_c);
    exp_w   = CMP_W'(s2_exp);
    mant_c  = '0;
    exp_c   = '0;
    loc_c   = s2_loc;
    zflag_c = 1'b0;
    ovf_c   = 1'b0;
    if (s2_zero) begin
      loc_c   = '0;
      zflag_c = 1'b1;
    end else if (s2_loc == TOP_LOC) begin
      // Carry into the top bit: already normalised, exponent bumps and may saturate.
      mant_c = {s2_sign, s2_mag};
      if (s2_exp == EXP_MAX) begin
        exp_c = EXP_MAX;
        ovf_c = 1'b1;
      end else begin
        exp_c = s2_exp + 1'b1;
      end
    end else if (shift_w < exp_w) begin
      mant_c = {s2_sign, s2_mag << shift_c};
      exp_c  = EXP_W'(exp_w - shift_w + 1'b1);
    end else begin
      // Not enough exponent headroom for a full shift: result is denormal.
      mant_c = {s2_sign, s2_mag << s2_exp};
      exp_c  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_mant <= '0;
      out_exp  <= '0;
      msb_loc  <= '0;
      out_zero <= 1'b0;
      out_ovf  <= 1'b0;
      out_tag  <= '0;
    end else if (load3) begin
      out_mant <= mant_c;
      out_exp  <= exp_c;
      msb_loc  <= loc_c;
      out_zero <= zflag_c;
      out_ovf  <= ovf_c;
      out_tag  <= s2_tag;
    end
  end

  assign out_valid = v3;

endmodule

// File: tb/tb_lod_normalizer_pipe.sv
// Directed bench for lod_normalizer_pipe: arithmetic vectors, latency, backpressure and reset.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_lod_normalizer_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] a, b;
  logic [7:0]  exponent;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [28:0] out_mant;
  logic [7:0]  out_exp;
  logic [4:0]  msb_loc;
  logic        out_zero;
  logic        out_ovf;
  logic [3:0]  out_tag;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  lod_normalizer_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .exponent  (exponent),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .msb_loc   (msb_loc),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .out_tag   (out_tag)
  );

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; exponent = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    compared++;
    if ({out_valid, out_mant, out_exp, msb_loc, out_zero, out_ovf, out_tag} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got valid=%b mant=%h exp=%0d loc=%0d z=%b o=%b tag=%0d, want all 0",
               out_valid, out_mant, out_exp, msb_loc, out_zero, out_ovf, out_tag);
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  // One beat through an idle pipe with out_ready high; checks latency and every field.
  task automatic run_vec(input string name, input logic [27:0] va, input logic [27:0] vb,
                         input logic [7:0] ve, input logic [3:0] vt,
                         input logic [28:0] em, input logic [7:0] ee, input logic [4:0] el,
                         input logic ez, input logic eo);
    int lat;
    a = va; b = vb; exponent = ve; in_tag = vt; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 8) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    compared++;
    if (!out_valid || lat != 2) begin
      mismatched++;
      $display("FAIL %s_latency: got valid=%b after %0d extra edges, want valid after 2", name, out_valid, lat);
    end
    compared++;
    if (out_mant !== em) begin
      mismatched++;
      $display("FAIL %s_mant: got %h want %h", name, out_mant, em);
    end
    compared++;
    if (out_exp !== ee) begin
      mismatched++;
      $display("FAIL %s_exp: got %0d want %0d", name, out_exp, ee);
    end
    compared++;
    if (msb_loc !== el) begin
      mismatched++;
      $display("FAIL %s_msb_loc: got %0d want %0d", name, msb_loc, el);
    end
    compared++;
    if ({out_zero, out_ovf} !== {ez, eo}) begin
      mismatched++;
      $display("FAIL %s_flags: got zero=%b ovf=%b want zero=%b ovf=%b", name, out_zero, out_ovf, ez, eo);
    end
    compared++;
    if (out_tag !== vt) begin
      mismatched++;
      $display("FAIL %s_tag: got %0d want %0d", name, out_tag, vt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_arith;
    run_vec("carry",      28'h4000000, 28'h4000000, 8'd10,  4'd1, 29'h08000000, 8'd11,  5'd27, 1'b0, 1'b0);
    run_vec("cancel",     28'h4000000, 28'hBFFFFFF, 8'd100, 4'd2, 29'h08000000, 8'd74,  5'd0,  1'b0, 1'b0);
    run_vec("denorm",     28'h4000000, 28'hBFFFFFF, 8'd5,   4'd3, 29'h00000020, 8'd0,   5'd0,  1'b0, 1'b0);
    run_vec("zero",       28'h0000005, 28'h8000005, 8'd50,  4'd4, 29'h00000000, 8'd0,   5'd0,  1'b1, 1'b0);
    run_vec("neg_zero",   28'h8000000, 28'h8000000, 8'd9,   4'd5, 29'h00000000, 8'd0,   5'd0,  1'b1, 1'b0);
    run_vec("ovf",        28'h4000000, 28'h4000000, 8'd255, 4'd6, 29'h08000000, 8'd255, 5'd27, 1'b0, 1'b1);
    // -3 + 1 = -2: sign kept, shift 26, exponent 40-26+1.
    run_vec("negative",   28'h8000003, 28'h0000001, 8'd40,  4'd7, 29'h18000000, 8'd15,  5'd1,  1'b0, 1'b0);
    // Leading one at bit 12 -> shift 15; exponent just above, equal to the shift.
    run_vec("shift_lt",   28'h0001000, 28'h0000000, 8'd16,  4'd8, 29'h08000000, 8'd2,   5'd12, 1'b0, 1'b0);
    run_vec("shift_eq",   28'h0001000, 28'h0000000, 8'd15,  4'd9, 29'h08000000, 8'd0,   5'd12, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    int acc;
    logic hs;
    logic [28:0] held_mant;
    logic [3:0]  held_tag;
    logic [3:0]  got[$];
    acc = 0; out_ready = 1'b0; b = '0; exponent = 8'd30;
    held_mant = '0; held_tag = '0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = (acc < 4);
      a = 28'(acc + 1); in_tag = 4'(acc + 1);
      @(negedge clk);
      hs = in_valid && in_ready;
      if (cyc == 3) begin
        held_mant = out_mant; held_tag = out_tag;
        compared++;
        if (out_valid !== 1'b1 || out_tag !== 4'd1) begin
          mismatched++;
          $display("FAIL stall_head: got valid=%b tag=%0d want valid=1 tag=1", out_valid, out_tag);
        end
      end else if (cyc > 3) begin
        compared++;
        if (out_valid !== 1'b1 || out_mant !== held_mant || out_tag !== held_tag) begin
          mismatched++;
          $display("FAIL stall_stable: got valid=%b mant=%h tag=%0d want valid=1 mant=%h tag=%0d",
                   out_valid, out_mant, out_tag, held_mant, held_tag);
        end
      end
      @(posedge clk);
      if (hs) acc++;
      #1;
    end
    @(negedge clk);
    compared++;
    if (acc != 3 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL full_pipe: got accepted=%0d in_ready=%b want accepted=3 in_ready=0", acc, in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && got.size() < 4; cyc++) begin
      in_valid = (acc < 4);
      a = 28'(acc + 1); in_tag = 4'(acc + 1);
      @(negedge clk);
      if (cyc == 0) begin
        compared++;
        if (in_ready !== 1'b1) begin
          mismatched++;
          $display("FAIL full_accept_drain: got in_ready=%b want 1", in_ready);
        end
      end
      if (out_valid) got.push_back(out_tag);
      hs = in_valid && in_ready;
      @(posedge clk);
      if (hs) acc++;
      #1;
    end
    in_valid = 1'b0;
    compared++;
    if (got.size() != 4) begin
      mismatched++;
      $display("FAIL drain_count: got %0d beats want 4", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      compared++;
      if (got[i] !== 4'(i + 1)) begin
        mismatched++;
        $display("FAIL drain_order[%0d]: got tag %0d want %0d", i, got[i], i + 1);
      end
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0; b = '0; exponent = 8'd30;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 28'(i + 1); in_tag = 4'(i + 10);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b1 || out_tag !== 4'd10) begin
      mismatched++;
      $display("FAIL pre_reset_head: got valid=%b tag=%0d want valid=1 tag=10", out_valid, out_tag);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_tag !== 4'd0) begin
      mismatched++;
      $display("FAIL mid_reset: got valid=%b in_ready=%b tag=%0d want valid=0 in_ready=1 tag=0",
               out_valid, in_ready, out_tag);
    end
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_flush: got out_valid=%b want 0 (stale beat after reset)", out_valid);
      end
    end
    @(posedge clk); #1;
    run_vec("after_rst", 28'h4000000, 28'h4000000, 8'd10, 4'd1, 29'h08000000, 8'd11, 5'd27, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
